// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline controller.
package core_pkg;

    typedef enum logic [1:0] {
        PC_NEXT,
        PC_BRANCH,
        PC_JAL,
        PC_JALR
    } pc_source_t;

    typedef enum logic [2:0] {
        PCS_NEXT,
        PCS_BRANCH,
        PCS_JAL,
        PCS_JALR,
        PCS_MTVEC,
        PCS_MEPC
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        TRAP_FLUSH,
        MRET_FLUSH
    } ctrl_state_t;

    localparam logic [4:0] MCAUSE_NONE          = 5'd0;
    localparam logic [4:0] MCAUSE_ILLEGAL_INSTR = 5'd2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: a load in EX writes a register that the ID instruction reads.
module hazard_detect
    import core_pkg::*;
(
    input  logic       valid_ex_i,
    input  logic       load_ex_i,
    input  logic [4:0] rd_addr_ex_i,
    input  logic [4:0] rs1_addr_id_i,
    input  logic [4:0] rs2_addr_id_i,
    output logic       hazard_o
);

    logic rd_match;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rd_match = (rd_addr_ex_i != 5'd0) &&
                      ((rd_addr_ex_i == rs1_addr_id_i) || (rd_addr_ex_i == rs2_addr_id_i));
    assign hazard_o = valid_ex_i && load_ex_i && rd_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stalls, flushes, next-PC select and trap/MRET sequencing.
//
// state      | meaning
// BOOT       | first cycle out of reset, pipeline held and flushed
// RUN        | normal issue, hazard and redirect arbitration
// TRAP_FLUSH | redirect to mtvec, both younger stages flushed
// MRET_FLUSH | redirect to mepc, both younger stages flushed
module pipeline_ctrl
    import core_pkg::*;
#(
    parameter int unsigned ISA_C = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_id_i,
    input  logic       illegal_instr_id_i,
    input  logic       is_mret_id_i,
    input  pc_source_t pc_source_id_i,
    input  logic [4:0] rs1_addr_id_i,
    input  logic [4:0] rs2_addr_id_i,
    input  logic       valid_ex_i,
    input  logic       reg_mem_wen_ex_i,
    input  logic [4:0] rd_addr_ex_i,
    input  logic       branch_taken_ex_i,
    input  logic       mem_busy_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       flush_id_o,
    output logic       flush_ex_o,
    output pc_sel_t    pc_sel_o,
    output logic       trap_o,
    output logic [4:0] mcause_o,
    output logic       mret_o
);

    // PC alignment lives in the fetch unit; the controller only carries the parameter.
    logic isa_c_unused;
    assign isa_c_unused = (ISA_C != 0);

    ctrl_state_t state_q, state_d;
    logic        load_use;

    hazard_detect u_hazard_detect (
        .valid_ex_i    (valid_ex_i),
        .load_ex_i     (reg_mem_wen_ex_i),
        .rd_addr_ex_i  (rd_addr_ex_i),
        .rs1_addr_id_i (rs1_addr_id_i),
        .rs2_addr_id_i (rs2_addr_id_i),
        .hazard_o      (load_use)
    );

    always_comb begin
        state_d    = state_q;
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        pc_sel_o   = PCS_NEXT;
        trap_o     = 1'b0;
        mcause_o   = MCAUSE_NONE;
        mret_o     = 1'b0;
        unique case (state_q)
            BOOT: begin
                stall_if_o = 1'b1;
                flush_id_o = 1'b1;
                flush_ex_o = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (mem_busy_i) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                end else if (branch_taken_ex_i && valid_ex_i) begin
                    pc_sel_o   = PCS_BRANCH;
                    flush_id_o = 1'b1;
                end else if (load_use) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                end else if (valid_id_i && illegal_instr_id_i) begin
                    trap_o   = 1'b1;
                    mcause_o = MCAUSE_ILLEGAL_INSTR;
                    state_d  = TRAP_FLUSH;
                end else if (valid_id_i && is_mret_id_i) begin
                    mret_o  = 1'b1;
                    state_d = MRET_FLUSH;
                end else if (valid_id_i && (pc_source_id_i == PC_JAL)) begin
                    pc_sel_o   = PCS_JAL;
                    flush_id_o = 1'b1;
                end else if (valid_id_i && (pc_source_id_i == PC_JALR)) begin
                    pc_sel_o   = PCS_JALR;
                    flush_id_o = 1'b1;
                end
            end
            TRAP_FLUSH, MRET_FLUSH: begin
                pc_sel_o   = (state_q == TRAP_FLUSH) ? PCS_MTVEC : PCS_MEPC;
                flush_id_o = 1'b1;
                flush_ex_o = 1'b1;
                // The redirect must not be lost while memory is busy, so keep it up.
                if (mem_busy_i) begin
                    stall_if_o = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter ISA_C, default 0, meaning compressed support, where 1 allows 2-byte PC alignment.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-003 SHALL have port rst_i, input, 1 bit, a reset that is asynchronous and active-high.
REQ-004 SHALL have port valid_id_i, input, 1 bit, meaning ID holds a live instruction.
REQ-005 SHALL have port illegal_instr_id_i, input, 1 bit, the decoder illegal flag.
REQ-006 SHALL have port is_mret_id_i, input, 1 bit, the decoder MRET flag.
REQ-007 SHALL have port pc_source_id_i, input, pc_source_t, the decoder PC source.
REQ-008 SHALL have ports rs1_addr_id_i and rs2_addr_id_i, input, 5 bits each, the ID source registers.
REQ-009 SHALL have port valid_ex_i, input, 1 bit, meaning EX holds a live instruction.
REQ-010 SHALL have port reg_mem_wen_ex_i, input, 1 bit, meaning EX holds a load.
REQ-011 SHALL have port rd_addr_ex_i, input, 5 bits, the EX destination register.
REQ-012 SHALL have port branch_taken_ex_i, input, 1 bit, meaning the EX branch resolved taken.
REQ-013 SHALL have port mem_busy_i, input, 1 bit, meaning the data memory is not ready.
REQ-014 SHALL have ports stall_if_o and stall_id_o, output, 1 bit each, the stage hold signals.
REQ-015 SHALL have ports flush_id_o and flush_ex_o, output, 1 bit each, which insert bubbles.
REQ-016 SHALL have port pc_sel_o, output, pc_sel_t, the next-PC mux select.
REQ-017 SHALL have port trap_o, output, 1 bit, the pulse to save the ID PC to mepc and write mcause.
REQ-018 SHALL have port mcause_o, output, 5 bits, the exception cause.
REQ-019 SHALL have port mret_o, output, 1 bit, the pulse to restore mstatus.

Function
REQ-020 SHALL implement the FSM states BOOT, RUN, TRAP_FLUSH and MRET_FLUSH.
REQ-021 SHALL, in BOOT, hold stall_if_o=1, flush_id_o=1 and flush_ex_o=1, then go to RUN after exactly one cycle.
REQ-022 SHALL evaluate RUN conditions by priority, highest first:
- (a) mem_busy_i: stall_if_o=stall_id_o=1, no flushes.
- (b) branch_taken_ex_i && valid_ex_i: pc_sel_o=PCS_BRANCH, flush_id_o=1, ID illegal/MRET ignored.
- (c) load-use hazard: stall_if_o=stall_id_o=1, flush_ex_o=1.
- (d) valid_id_i && illegal_instr_id_i: trap_o=1, mcause_o=2, go to TRAP_FLUSH.
- (e) valid_id_i && is_mret_id_i: mret_o=1, go to MRET_FLUSH.
- (f) valid_id_i && pc_source_id_i is JAL or JALR: pc_sel_o=PCS_JAL or PCS_JALR, flush_id_o=1.
- (g) otherwise: pc_sel_o=PCS_NEXT, all other outputs 0.
REQ-023 SHALL detect a load-use hazard as valid_ex_i && reg_mem_wen_ex_i && rd_addr_ex_i!=0 && rd_addr_ex_i equal to rs1_addr_id_i or rs2_addr_id_i.
REQ-024 SHALL treat a PC_BRANCH pc_source_id_i as no ID redirect, because branches resolve in EX.
REQ-025 SHALL, in TRAP_FLUSH (one cycle), drive pc_sel_o=PCS_MTVEC, flush_id_o=1 and flush_ex_o=1, then go to RUN.
REQ-026 SHALL, in MRET_FLUSH (one cycle), drive pc_sel_o=PCS_MEPC, flush_id_o=1 and flush_ex_o=1, then go to RUN.
REQ-027 SHALL hold its state during mem_busy_i in TRAP_FLUSH or MRET_FLUSH, additionally asserting stall_if_o.
REQ-028 SHALL keep trap_o and mret_o as one-cycle pulses, asserted only on the RUN-exit cycle and never both.
REQ-029 SHALL generate all outputs combinationally from the state and inputs, with zero-cycle decision latency.
REQ-030 SHALL give valid_id_i=0 precedence over any other ID flag, so no trap, MRET or redirect occurs.

Reset
REQ-031 SHALL, while rst_i=1, force the state to BOOT immediately with stall_if_o=1, flush_id_o=1, flush_ex_o=1, pc_sel_o=PCS_NEXT, trap_o=0, mret_o=0 and mcause_o=0.
REQ-032 SHALL, on reset assertion mid-TRAP_FLUSH or mid-MRET_FLUSH, abandon that state, and no trap or MRET pulse is repeated.

Structure
REQ-033 SHALL place pc_sel_t (PCS_NEXT, PCS_BRANCH, PCS_JAL, PCS_JALR, PCS_MTVEC, PCS_MEPC), the FSM state type and the mcause constants in core_pkg.
REQ-034 SHALL contain one sub-module, hazard_detect, which computes the combinational load-use hazard.

Verification
REQ-035 SHALL cover reset release: BOOT for 1 cycle, then RUN with pc_sel_o=PCS_NEXT and stall/flush=0.
REQ-036 SHALL cover a load-use hazard: load rd=5 in EX with rs2_id=5 gives 1 stall cycle and flush_ex_o=1, while rd=0 gives no stall.
REQ-037 SHALL cover an illegal instruction with a taken branch in the same cycle: only pc_sel_o=PCS_BRANCH, trap_o=0.
REQ-038 SHALL cover an illegal instruction in ID alone: trap_o=1 and mcause_o=2, next cycle PCS_MTVEC with both flushes, then RUN.
REQ-039 SHALL cover MRET under mem_busy_i: nothing until busy drops, then mret_o=1, then PCS_MEPC held while busy re-asserts.
REQ-040 SHALL cover rst_i asserted in TRAP_FLUSH: immediate BOOT outputs, and after release no second trap_o.
